// File: rtl/sat_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sat_add_arbiter
// Purpose  : Shares one signed saturating adder between NREQ requesters.
//            A round-robin arbiter picks one valid requester per cycle.
//            Its operands are added with signed saturation. The result goes
//            into a one-entry output register, tagged with the requester
//            index and a saturation flag.
// Ports    : clk, rst (async, active high)
//            req_valid/req_ready [NREQ]   per-requester handshake
//            req_a/req_b [NREQ*WIDTH]     packed operands, slot i at i*WIDTH
//            rsp_valid/rsp_ready          result handshake
//            rsp_id, rsp_result, rsp_sat  result payload
//            sat_count [16]               saturation event counter
// Config   : SAT_ADD_ARB_STATS_EN builds the saturating sat_count counter.
//            Without it, sat_count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module sat_add_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_sat,
  output logic [15:0]           sat_count
);

  localparam logic [IDW:0]   C_NREQ = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] C_LAST = IDW'(NREQ-1);
  localparam logic [IDW-1:0] C_ONE  = IDW'(1);

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_sat_q, rsp_sat_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;

  logic             can_accept;
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW:0]     cand;
  logic             xfer;

  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];
  logic [WIDTH-1:0] sel_a, sel_b, raw_sum, sum_res;
  logic             sum_sat;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign op_a[gi] = req_a[gi*WIDTH +: WIDTH];
    assign op_b[gi] = req_b[gi*WIDTH +: WIDTH];
  end

  // Scan ptr, ptr+1, ... mod NREQ. The first valid requester wins.
  // The extra bit in cand makes the wrap exact when NREQ is not a power of two.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= C_NREQ) begin
        cand = cand - C_NREQ;
      end
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // Reset also gates the grant, so req_ready is low while rst is held.
  assign can_accept = !rst && (!rsp_valid_q || rsp_ready);
  assign xfer       = can_accept && grant_found;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign sel_a   = op_a[grant_idx];
  assign sel_b   = op_b[grant_idx];
  assign raw_sum = sel_a + sel_b;

  // Overflow is possible only when both operands share a sign and the
  // raw sum's sign differs from it.
  always_comb begin
    sum_res = raw_sum;
    sum_sat = 1'b0;
    if (!sel_a[WIDTH-1] && !sel_b[WIDTH-1] && raw_sum[WIDTH-1]) begin
      sum_res = {1'b0, {(WIDTH-1){1'b1}}};
      sum_sat = 1'b1;
    end else if (sel_a[WIDTH-1] && sel_b[WIDTH-1] && !raw_sum[WIDTH-1]) begin
      sum_res = {1'b1, {(WIDTH-1){1'b0}}};
      sum_sat = 1'b1;
    end
  end

  // A drain alone empties the register. A refill in the same cycle keeps it
  // full with the new payload. With no handshake, the payload is held.
  always_comb begin
    ptr_d        = ptr_q;
    rsp_valid_d  = rsp_valid_q && !rsp_ready;
    rsp_result_d = rsp_result_q;
    rsp_sat_d    = rsp_sat_q;
    rsp_id_d     = rsp_id_q;
    if (xfer) begin
      ptr_d        = (grant_idx == C_LAST) ? '0 : grant_idx + C_ONE;
      rsp_valid_d  = 1'b1;
      rsp_result_d = sum_res;
      rsp_sat_d    = sum_sat;
      rsp_id_d     = grant_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_sat_q    <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      ptr_q        <= ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_sat_q    <= rsp_sat_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_sat    = rsp_sat_q;
  assign rsp_id     = rsp_id_q;

`ifdef SAT_ADD_ARB_STATS_EN
  logic [15:0] sat_count_q, sat_count_d;

  // Counts saturating transfers. The counter sticks at all-ones.
  always_comb begin
    sat_count_d = sat_count_q;
    if (xfer && sum_sat && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count_q <= 16'h0000;
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

  assign sat_count = sat_count_q;
`else
  assign sat_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sat_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sat_add_arbiter
// Purpose  : Self-checking bench for sat_add_arbiter (WIDTH=8, NREQ=4).
//            A transaction-level model predicts the grants and payloads.
//            It uses integer-clamped sums and a modulo pointer scan.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sat_add_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_sat;
  logic [15:0]           sat_count;

  sat_add_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_sat    (rsp_sat),
    .sat_count  (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit       m_valid;
  int       m_ptr;
  int       m_res;
  bit       m_sat;
  int       m_id;
  int       m_cnt;
  int       last_grant;
  logic [3:0] last_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int idx, input logic [7:0] v);
    logic [31:0] w;
    w = {24'h0, v};
    return w << (idx * 8);
  endfunction

  task automatic m_reset();
    m_valid = 0; m_ptr = 0; m_res = 0; m_sat = 0; m_id = 0; m_cnt = 0;
  endtask

  // Signed add on plain integers, clamped to the 8-bit signed range.
  task automatic ref_add(input logic [7:0] a, input logic [7:0] b,
                         output int r, output bit s);
    int sum;
    sum = int'($signed(a)) + int'($signed(b));
    if (sum > 127) begin
      r = 127; s = 1;
    end else if (sum < -128) begin
      r = -128; s = 1;
    end else begin
      r = sum; s = 0;
    end
    r = r & 32'hFF;
  endtask

  task automatic check_outputs();
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("rsp_result", {24'b0, rsp_result}, 32'(m_res));
      chk("rsp_sat", {31'b0, rsp_sat}, {31'b0, m_sat});
      chk("rsp_id", {30'b0, rsp_id}, 32'(m_id));
    end
`ifdef SAT_ADD_ARB_STATS_EN
    chk("sat_count", {16'b0, sat_count}, 32'(m_cnt));
`else
    chk("sat_count", {16'b0, sat_count}, 32'h0);
`endif
  endtask

  // One clock cycle: drive, check the combinational grant, clock, check the register.
  task automatic cycle(input logic [3:0] v, input logic [31:0] a,
                       input logic [31:0] b, input logic rr);
    int g;
    int r;
    bit s;
    logic [3:0] exp_ready;
    req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
    #2;
    g = -1;
    if (!m_valid || rr) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (g < 0 && v[i]) g = i;
      end
    end
    exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
    last_ready = req_ready;
    last_grant = -1;
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) last_grant = i;
    chk("req_ready", {28'b0, req_ready}, {28'b0, exp_ready});
    @(posedge clk);
    #1;
    if (g >= 0) begin
      ref_add(a[g*8 +: 8], b[g*8 +: 8], r, s);
      m_valid = 1; m_res = r; m_sat = s; m_id = g;
      m_ptr = (g + 1) % NREQ;
      if (s && m_cnt < 65535) m_cnt++;
    end else if (rr) begin
      m_valid = 0;
    end
    check_outputs();
  endtask

  // Asserts reset between edges, checks the asynchronous clear, then releases it.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_result", {24'b0, rsp_result}, 32'h0);
    chk("rst_rsp_sat", {31'b0, rsp_sat}, 32'h0);
    chk("rst_rsp_id", {30'b0, rsp_id}, 32'h0);
    chk("rst_sat_count", {16'b0, sat_count}, 32'h0);
    chk("rst_req_ready", {28'b0, req_ready}, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    m_reset();
  endtask

  int rr_seq [6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    m_reset();
    last_grant = -1; last_ready = '0;
    @(posedge clk);
    #1;
    req_valid = 4'hF; rsp_ready = 1'b1;
    do_reset();

    // First grant after reset goes to requester 0; then reset while full.
    cycle(4'hF, 32'h0403_0201, 32'h0101_0101, 1'b0);
    chk("first_grant", 32'(last_grant), 32'd0);
    chk("full_before_rst", {31'b0, rsp_valid}, 32'h1);
    req_valid = 4'hF;
    do_reset();
    cycle(4'hF, 32'h0, 32'h0, 1'b1);
    chk("grant_after_rst", 32'(last_grant), 32'd0);

    // Arithmetic through requester 2
    cycle(4'b0100, pk(2, 8'h10), pk(2, 8'h05), 1'b1);
    chk("add_15_res", {24'b0, rsp_result}, 32'h15);
    chk("add_15_sat", {31'b0, rsp_sat}, 32'h0);
    chk("add_15_id", {30'b0, rsp_id}, 32'h2);
    cycle(4'b0100, pk(2, 8'h70), pk(2, 8'h20), 1'b1);
    chk("pos_ovf_res", {24'b0, rsp_result}, 32'h7F);
    chk("pos_ovf_sat", {31'b0, rsp_sat}, 32'h1);
    cycle(4'b0100, pk(2, 8'h80), pk(2, 8'hFF), 1'b1);
    chk("neg_ovf_res", {24'b0, rsp_result}, 32'h80);
    chk("neg_ovf_sat", {31'b0, rsp_sat}, 32'h1);
    cycle(4'b0100, pk(2, 8'h7F), pk(2, 8'h81), 1'b1);
    chk("mixed_res", {24'b0, rsp_result}, 32'h00);
    chk("mixed_sat", {31'b0, rsp_sat}, 32'h0);
    chk("mixed_id", {30'b0, rsp_id}, 32'h2);

    // Round-robin over 4'b1011, starting from pointer 0
    cycle(4'b1000, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(4'b1011, $urandom, $urandom, 1'b1);
      chk("rr_grant", 32'(last_grant), 32'(rr_seq[i]));
      chk("rr_ready2", {31'b0, last_ready[2]}, 32'h0);
    end

    // Backpressure: hold 0x15 while requester 1 waits
    cycle(4'b0100, pk(2, 8'h10), pk(2, 8'h05), 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0010, $urandom, $urandom, 1'b0);
      chk("bp_ready", {28'b0, last_ready}, 32'h0);
      chk("bp_hold_res", {24'b0, rsp_result}, 32'h15);
      chk("bp_hold_id", {30'b0, rsp_id}, 32'h2);
    end
    cycle(4'b0010, pk(1, 8'h03), pk(1, 8'h04), 1'b1);
    chk("refill_ready", {28'b0, last_ready}, 32'h2);
    chk("refill_valid", {31'b0, rsp_valid}, 32'h1);
    chk("refill_id", {30'b0, rsp_id}, 32'h1);
    chk("refill_res", {24'b0, rsp_result}, 32'h07);

    // Drain to empty; the pointer keeps its value
    cycle(4'b0000, 32'h0, 32'h0, 1'b1);
    chk("drain_valid", {31'b0, rsp_valid}, 32'h0);
    cycle(4'b1111, 32'h0, 32'h0, 1'b1);
    chk("ptr_held", 32'(last_grant), 32'd2);

    // Statistics: 3 saturating and 2 non-saturating additions
    do_reset();
    cycle(4'b0001, pk(0, 8'h70), pk(0, 8'h20), 1'b1);
    cycle(4'b0001, pk(0, 8'h10), pk(0, 8'h05), 1'b1);
    cycle(4'b0001, pk(0, 8'h80), pk(0, 8'hFF), 1'b1);
    cycle(4'b0001, pk(0, 8'h7F), pk(0, 8'h81), 1'b1);
    cycle(4'b0001, pk(0, 8'h7F), pk(0, 8'h01), 1'b1);
`ifdef SAT_ADD_ARB_STATS_EN
    chk("stats_count", {16'b0, sat_count}, 32'd3);
`else
    chk("stats_count", {16'b0, sat_count}, 32'd0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      cycle(4'($urandom), $urandom, $urandom, 1'($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/sat_add_arbiter.md
# sat_add_arbiter

Shares one signed saturating adder between `NREQ` requesters using round-robin arbitration with valid/ready handshakes on both sides. Each accepted request is added with signed saturation and placed in a one-entry output register, tagged with the requester index and a saturation flag. The block sits between execution-side clients, such as multiple DSP-style or accumulate units, and a single shared adder datapath. It keeps one adder instance per cluster while guaranteeing fairness and full-throughput back-to-back operation.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width in bits (≥ 2).
- `NREQ`, 4, number of requesters (2..16).
- `IDW`, `$clog2(NREQ)`, width of the requester tag.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester grant/accept, combinational.
- `req_a`  in  NREQ*WIDTH  operand A; requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `req_b`  in  NREQ*WIDTH  operand B, same packing as `req_a`.
- `rsp_valid`  out  1  output register holds a result.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  IDW  index of the requester that produced the result.
- `rsp_result`  out  WIDTH  saturated sum.
- `rsp_sat`  out  1  saturation occurred for this result.
- `sat_count`  out  16  saturation event counter (see Configuration).

## Operation
- **Output register states.** EMPTY (`rsp_valid`=0) and FULL (`rsp_valid`=1).
- **Accept condition.** `can_accept = !rsp_valid || rsp_ready`.
- **Arbitration.** Round-robin pointer `ptr` (IDW bits). If `can_accept` is true and any `req_valid` is set, grant the first set bit scanning `ptr`, `ptr+1`, …, wrapping mod `NREQ`.
- **Grant.** Only the granted requester sees `req_ready`=1. All other `req_ready` bits are 0. If `can_accept`=0, all `req_ready` bits are 0.
- **Handshake.** A transfer occurs when `req_valid[i] && req_ready[i]`.
  - On a transfer, `ptr` becomes `i+1` (wrapping to 0 after `NREQ-1`).
  - If no transfer occurs, `ptr` is unchanged.
- **Arithmetic.** The sum is a WIDTH-bit two's-complement add of A and B. Let `sA`, `sB`, `sR` be the MSBs of A, B and the raw sum.
  - Positive overflow (`!sA && !sB && sR`): result = `{0, all 1s}` (maximum positive), `sat`=1.
  - Negative overflow (`sA && sB && !sR`): result = `{1, all 0s}` (most negative), `sat`=1.
  - Otherwise: result = raw sum, `sat`=0.
  - Mixed-sign operands never saturate.
- **On a transfer.** `rsp_result`, `rsp_sat` and `rsp_id` are loaded and `rsp_valid` is set to 1.
- **Drain without refill.** If `rsp_valid && rsp_ready` and there is no new transfer, `rsp_valid` goes to 0.
- **Simultaneous drain and refill.** If the register drains and refills in the same cycle, `rsp_valid` stays 1 with the new payload. This gives full throughput.
- **Stable outputs.** While `rsp_valid && !rsp_ready`, `rsp_result`, `rsp_sat` and `rsp_id` must not change.
- **Withdrawn requests.** A requester may drop `req_valid` without a transfer. No state changes as a result.

## Timing
- **Reset values.** While `rst` is asserted:
  - `rsp_valid`=0, `rsp_result`=0, `rsp_sat`=0, `rsp_id`=0.
  - `ptr`=0, `sat_count`=0.
  - `req_ready`=0 (this follows from `rst` forcing the grant off).
- **Reset mid-operation.** A result held in the output register is discarded without being delivered.
- **Latency.** The result is visible the cycle after acceptance: request at edge N gives `rsp_valid` after edge N. There is no combinational path from `req_a`/`req_b` to `rsp_*`.
- **Combinational paths.**
  - `req_ready` depends on `req_valid`, `ptr`, `rsp_valid` and `rsp_ready`.
  - No output depends on `req_a` or `req_b` combinationally.
- **Throughput.** One operation per cycle when `rsp_ready` is held at 1.
- **Fairness.** With all requesters continuously valid, grants rotate 0, 1, …, NREQ-1, 0, …. Each requester waits at most NREQ-1 grants.

## Configuration
- Macro: `SAT_ADD_ARB_STATS_EN`.
- **Defined:**
  - `sat_count` increments by 1 on every transfer whose computed `sat`=1.
  - It saturates at 0xFFFF and does not wrap.
  - It is cleared only by `rst`.
- **Undefined:**
  - No counter logic is built.
  - `sat_count` is tied to 16'h0000.
  - All other behaviour is identical.

## Test plan
Parameters for all scenarios: `WIDTH`=8, `NREQ`=4.
- **Reset.** Assert `rst` mid-transfer with `rsp_valid`=1 and `req_valid`=4'b1111. Require all outputs 0 asynchronously. After release, require the first grant to go to requester 0.
- **Arithmetic.** Requester 2 sends 0x10+0x05, then 0x70+0x20, then 0x80+0xFF, then 0x7F+0x81. Require `rsp_result`/`rsp_sat` = 0x15/0, 0x7F/1, 0x80/1, 0x00/0, each with `rsp_id`=2.
- **Round-robin.** Hold `req_valid`=4'b1011 with `rsp_ready`=1 for 6 cycles. Require the grant sequence 0, 1, 3, 0, 1, 3 and `req_ready[2]`=0 throughout.
- **Backpressure.**
  - Hold `rsp_ready`=0 with result 0x15 held. Require `req_ready`=0 and the payload stable for 5 cycles.
  - Raise `rsp_ready` with `req_valid[1]` pending. Require the drain and the new load in the same cycle, and `rsp_valid` to stay 1.
- **Drain to empty.** Send a single request, then hold `req_valid`=0 with `rsp_ready`=1. Require `rsp_valid` to drop to 0 after one cycle, and `ptr` to hold its value.
- **Statistics, with `SAT_ADD_ARB_STATS_EN` defined.** Issue 3 saturating additions and 2 non-saturating additions. Require `sat_count`=3. Without the macro, require `sat_count`=0.
